// File: rtl/studio2_keypad.sv
// studio2_keypad: PS/2 events -> RCA Studio II keypads A/B and EF3/EF4 scan.
// Define STUDIO2_KEY_STRETCH_EN to stretch short taps to HOLD_CYCLES.
module studio2_keypad #(
  parameter int CNT_W       = 20,
  parameter int HOLD_CYCLES = 700000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        key_sel_wr,
  input  logic [3:0]  key_sel_data,
  output logic [3:0]  key_sel,
  output logic [9:0]  keys_a,
  output logic [9:0]  keys_b,
  output logic        ef3,
  output logic        ef4
);
  localparam int NK = 20;

  logic          prev_q;
  logic          primed_q;
  logic [3:0]    sel_q;
  logic          ev;
  logic          mk;
  logic [NK-1:0] hit;
  logic [NK-1:0] down;

  assign ev = primed_q && (ps2_key[10] != prev_q);
  assign mk = ps2_key[9];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      prev_q   <= ps2_key[10];
      primed_q <= 1'b1;
      if (key_sel_wr) sel_q <= key_sel_data;
    end
  end

  // bits 9:0 = pad A (main row), bits 19:10 = pad B (numpad)
  always_comb begin
    hit = '0;
    unique case (ps2_key[7:0])
      8'h45:   hit[0]  = 1'b1;
      8'h16:   hit[1]  = 1'b1;
      8'h1E:   hit[2]  = 1'b1;
      8'h26:   hit[3]  = 1'b1;
      8'h25:   hit[4]  = 1'b1;
      8'h2E:   hit[5]  = 1'b1;
      8'h36:   hit[6]  = 1'b1;
      8'h3D:   hit[7]  = 1'b1;
      8'h3E:   hit[8]  = 1'b1;
      8'h46:   hit[9]  = 1'b1;
      8'h70:   hit[10] = 1'b1;
      8'h69:   hit[11] = 1'b1;
      8'h72:   hit[12] = 1'b1;
      8'h7A:   hit[13] = 1'b1;
      8'h6B:   hit[14] = 1'b1;
      8'h73:   hit[15] = 1'b1;
      8'h74:   hit[16] = 1'b1;
      8'h6C:   hit[17] = 1'b1;
      8'h75:   hit[18] = 1'b1;
      8'h7D:   hit[19] = 1'b1;
      default: hit = '0;
    endcase
    if (!ev || ps2_key[8]) hit = '0;
  end

`ifdef STUDIO2_KEY_STRETCH_EN
  typedef enum logic [1:0] {
    IDLE,
    HELD,
    PEND_REL
  } kst_t;

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  kst_t             st_q  [NK];
  kst_t             st_d  [NK];
  logic [CNT_W-1:0] cnt_q [NK];
  logic [CNT_W-1:0] cnt_d [NK];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NK; k++) begin
        st_q[k]  <= IDLE;
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // A key releases on the edge where its counter reaches zero.
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      st_d[k]  = st_q[k];
      cnt_d[k] = (cnt_q[k] != '0) ? cnt_q[k] - ONE : '0;
      unique case (st_q[k])
        HELD: begin
          if (hit[k] && !mk)
            st_d[k] = (cnt_q[k] <= ONE) ? IDLE : PEND_REL;
        end
        PEND_REL: begin
          if (cnt_q[k] <= ONE) st_d[k] = IDLE;
        end
        default: ;
      endcase
      if (hit[k] && mk) begin
        st_d[k]  = HELD;
        cnt_d[k] = HOLD;
      end
      down[k] = (st_q[k] != IDLE);
    end
  end
`else
  logic [NK-1:0] keys_q;
  logic          unused_cfg;

  assign unused_cfg = (CNT_W > 0) ^ (HOLD_CYCLES > 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) keys_q <= '0;
    else keys_q <= (keys_q | (hit & {NK{mk}}))
                 & ~(hit & {NK{!mk}});
  end

  assign down = keys_q;
`endif

  assign key_sel = sel_q;
  assign keys_a  = down[9:0];
  assign keys_b  = down[19:10];
  assign ef3     = (sel_q < 4'd10) ? keys_a[sel_q] : 1'b0;
  assign ef4     = (sel_q < 4'd10) ? keys_b[sel_q] : 1'b0;

endmodule

// File: tb/tb_studio2_keypad.sv
// tb_studio2_keypad: randomized + directed bench with scoreboard queue
// and a cycle-count reference model of the keypad hold behaviour.
module tb_studio2_keypad;
  localparam int HOLD = 16;
`ifdef STUDIO2_KEY_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  localparam logic [7:0] SA [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                     8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] SB [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                     8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        key_sel_wr;
  logic [3:0]  key_sel_data;
  logic [3:0]  key_sel;
  logic [9:0]  keys_a;
  logic [9:0]  keys_b;
  logic        ef3;
  logic        ef4;

  always #5 clk = ~clk;

  studio2_keypad #(.CNT_W(20), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key),
    .key_sel_wr(key_sel_wr), .key_sel_data(key_sel_data),
    .key_sel(key_sel), .keys_a(keys_a), .keys_b(keys_b),
    .ef3(ef3), .ef4(ef4)
  );

  typedef struct {
    string      name;
    logic [9:0] a;
    logic [9:0] b;
    logic [3:0] sel;
    logic       e3;
    logic       e4;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: per-key down flag, make time, pending release
  bit         down [20];
  bit         pend [20];
  int         mkt  [20];
  int         t = 0;
  bit         primed = 1'b0;
  bit         prev = 1'b0;
  logic [3:0] sel_m = '0;

  function automatic int lookup(logic [7:0] sc);
    for (int i = 0; i < 10; i++) begin
      if (SA[i] == sc) return i;
      if (SB[i] == sc) return 10 + i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 20; k++) begin
      down[k] = 1'b0;
      pend[k] = 1'b0;
    end
    sel_m  = '0;
    primed = 1'b0;
  endtask

  task automatic model_edge();
    bit ev;
    int k;
    if (reset) begin
      model_reset();
      return;
    end
    ev     = primed && (ps2_key[10] != prev);
    prev   = ps2_key[10];
    primed = 1'b1;
    t++;
    for (int j = 0; j < 20; j++)
      if (pend[j] && t == mkt[j] + HOLD) begin
        down[j] = 1'b0;
        pend[j] = 1'b0;
      end
    if (ev && !ps2_key[8]) begin
      k = lookup(ps2_key[7:0]);
      if (k >= 0) begin
        if (ps2_key[9]) begin
          down[k] = 1'b1;
          mkt[k]  = t;
          pend[k] = 1'b0;
        end else if (down[k]) begin
          if (!STRETCH || t >= mkt[k] + HOLD) down[k] = 1'b0;
          else pend[k] = 1'b1;
        end
      end
    end
    if (key_sel_wr) sel_m = key_sel_data;
  endtask

  task automatic push_exp(string name);
    exp_t e;
    e.name = name;
    for (int k = 0; k < 10; k++) begin
      e.a[k] = down[k];
      e.b[k] = down[10 + k];
    end
    e.sel = sel_m;
    e.e3  = (sel_m < 10) ? e.a[sel_m] : 1'b0;
    e.e4  = (sel_m < 10) ? e.b[sel_m] : 1'b0;
    q.push_back(e);
    -> chk_ev;
  endtask

  // monitor: DUT output is presented after each edge (or async reset)
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (keys_a !== e.a || keys_b !== e.b || key_sel !== e.sel ||
            ef3 !== e.e3 || ef4 !== e.e4) begin
          n_bad++;
          $display("FAIL %s t=%0t: got a=%h b=%h sel=%0d ef3=%b ef4=%b",
                   e.name, $time, keys_a, keys_b, key_sel, ef3, ef4);
          $display("  expected a=%h b=%h sel=%0d ef3=%b ef4=%b",
                   e.a, e.b, e.sel, e.e3, e.e4);
        end
      end
    end
  end

  // caller drives inputs at negedge, then one edge is taken and checked
  task automatic cycle(string name);
    @(posedge clk);
    model_edge();
    #1;
    push_exp(name);
    @(negedge clk);
    key_sel_wr = 1'b0;
  endtask

  task automatic idle(int n, string name);
    for (int i = 0; i < n; i++) cycle(name);
  endtask

  task automatic send(bit make, bit ext, logic [7:0] sc);
    ps2_key = {~ps2_key[10], make, ext, sc};
  endtask

  task automatic wsel(logic [3:0] d);
    key_sel_wr   = 1'b1;
    key_sel_data = d;
  endtask

  initial begin
    int r;
    int k;
    logic [7:0] sc;
    reset        = 1'b1;
    ps2_key      = 11'h400;
    key_sel_wr   = 1'b0;
    key_sel_data = '0;
    model_reset();
    @(negedge clk);
    idle(2, "reset");
    reset = 1'b0;
    idle(3, "post_reset_idle");

    send(1, 0, 8'h16);
    wsel(4'd1);
    cycle("make_a1_sel1");
    idle(2, "a1_held_ef3");
    wsel(4'd12);
    cycle("sel12_ef_zero");
    wsel(4'd1);
    idle(20, "a1_long_hold");
    send(0, 0, 8'h16);
    cycle("break_a1_late");
    idle(2, "a1_released");

    send(1, 0, 8'h69);
    cycle("make_b1");
    idle(3, "b1_short");
    send(0, 0, 8'h69);
    cycle("break_b1_early");
    idle(16, "b1_stretch");

    wsel(4'd0);
    send(1, 0, 8'h70);
    cycle("make_b0");
    idle(40, "b0_hold40");
    send(0, 0, 8'h70);
    cycle("break_b0");
    idle(2, "b0_released");

    send(1, 0, 8'h69);
    cycle("make_b1_again");
    send(0, 0, 8'h69);
    cycle("break_b1_pend");
    idle(3, "b1_pend");
    send(1, 0, 8'h72);
    cycle("make_b2_other");
    send(1, 0, 8'h72);
    cycle("repeat_b2");
    idle(3, "b1_timing");
    send(1, 0, 8'h69);
    cycle("remake_b1_pend");
    send(0, 0, 8'h69);
    cycle("break_b1_again");
    send(0, 0, 8'h72);
    cycle("break_b2");
    idle(20, "pend_drain");

    send(1, 1, 8'h6B);
    cycle("ext_make_ignored");
    send(1, 0, 8'h1C);
    cycle("unmapped_ignored");
    idle(2, "ignored_idle");

    send(1, 0, 8'h6B);
    cycle("make_b4");
    send(0, 0, 8'h6B);
    cycle("break_b4");
    idle(2, "b4_pend");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    push_exp("async_reset");
    send(1, 0, 8'h16);
    @(negedge clk);
    idle(2, "in_reset");
    reset = 1'b0;
    idle(4, "no_spurious_event");

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        k = $urandom_range(0, 21);
        if (k < 10) sc = SA[k];
        else if (k < 20) sc = SB[k - 10];
        else sc = 8'h1C;
        send($urandom_range(0, 1) == 1, k == 21, k == 21 ? 8'h6B : sc);
      end
      if ($urandom_range(0, 7) == 0) wsel(4'($urandom_range(0, 15)));
      cycle("random");
    end
    idle(HOLD + 2, "random_drain");

    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
